// File: rtl/uart_rx_core.sv
// uart_rx_core
// UART receive engine. Oversamples the already-synchronized serial line,
// finds the start bit, takes a three-sample majority vote in the middle of
// every bit, deserializes DATA_WIDTH data bits LSB first, optionally checks a
// parity bit and always checks one stop bit. A completed frame produces a
// single-cycle pulse on data_valid (good frame) or on par_err / stp_err.

module uart_rx_core #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_in,
   input  logic [5:0]            prescale,
   input  logic                  par_en,
   input  logic                  par_type,
   output logic [DATA_WIDTH-1:0] p_data,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   localparam int BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                state;

   // Frame configuration frozen at start detection
   logic [5:0]            presc_q;
   logic                  par_en_q;
   logic                  par_type_q;

   // Oversampling position inside the current bit
   logic [5:0]            edge_cnt;
   logic [5:0]            half;

   // Mid-bit samples and their registered majority
   logic [2:0]            samples;
   logic                  majority;

   // Deserializer
   logic [BitCntW-1:0]    bit_cnt;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic                  par_fail;

   logic                  start_det;
   logic                  bit_end;
   logic                  expected_par;

   // A low level seen while idle starts a frame; that edge is edge 0 of the start bit.
   assign start_det = (state == IDLE) && !rx_in;

   // Centre of a bit in oversampling ticks; prescale is always even.
   assign half = {1'b0, presc_q[5:1]};

   // Last oversampling tick of the current bit.
   assign bit_end = (state != IDLE) && (edge_cnt == (presc_q - 6'd1));

   // Parity expected over the received word, matching the transmitter's rule.
   assign expected_par = par_type_q ? (^shift_reg) : ~(^shift_reg);

   // Freeze prescale and parity configuration for the whole frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q    <= 6'd0;
         par_en_q   <= 1'b0;
         par_type_q <= 1'b0;
      end else if (start_det) begin
         presc_q    <= prescale;
         par_en_q   <= par_en;
         par_type_q <= par_type;
      end
   end

   // Oversampling tick counter; starts at 1 because the detection edge was tick 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         edge_cnt <= 6'd0;
      end else if (start_det) begin
         edge_cnt <= 6'd1;
      end else if (state == IDLE) begin
         edge_cnt <= 6'd0;
      end else if (bit_end) begin
         edge_cnt <= 6'd0;
      end else begin
         edge_cnt <= edge_cnt + 6'd1;
      end
   end

   // Take three samples around the bit centre and register their majority two ticks later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         samples  <= 3'b000;
         majority <= 1'b0;
      end else if (state != IDLE) begin
         if (edge_cnt == (half - 6'd1)) begin
            samples[0] <= rx_in;
         end
         if (edge_cnt == half) begin
            samples[1] <= rx_in;
         end
         if (edge_cnt == (half + 6'd1)) begin
            samples[2] <= rx_in;
         end
         if (edge_cnt == (half + 6'd2)) begin
            majority <= (samples[0] & samples[1]) |
                        (samples[0] & samples[2]) |
                        (samples[1] & samples[2]);
         end
      end
   end

   // Frame FSM: walks start/data/parity/stop on bit boundaries and issues the result pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         par_fail   <= 1'b0;
         p_data     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;

         case (state)
            IDLE: begin
               if (start_det) begin
                  state     <= START;
                  bit_cnt   <= '0;
                  shift_reg <= '0;
                  par_fail  <= 1'b0;
               end
            end

            START: begin
               if (bit_end) begin
                  if (majority) begin
                     state <= IDLE;
                  end else begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
            end

            DATA: begin
               if (bit_end) begin
                  shift_reg[bit_cnt] <= majority;
                  if (bit_cnt == LastBit) begin
                     state <= par_en_q ? PARITY : STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end

            PARITY: begin
               if (bit_end) begin
                  par_fail <= (majority != expected_par);
                  state    <= STOP;
               end
            end

            STOP: begin
               if (bit_end) begin
                  state   <= IDLE;
                  par_err <= par_fail;
                  stp_err <= !majority;
                  if (!par_fail && majority) begin
                     data_valid <= 1'b1;
                     p_data     <= shift_reg;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core
// Drives whole UART frames cycle by cycle and compares the result pulses
// (cycle, kind, word) against a frame-level model of what a receiver must
// report for each frame.

module tb_uart_rx_core;

   localparam int DW = 8;

   logic          clk;
   logic          reset;
   logic          rx_in;
   logic [5:0]    prescale;
   logic          par_en;
   logic          par_type;
   logic [DW-1:0] p_data;
   logic          data_valid;
   logic          par_err;
   logic          stp_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct packed {
      int            t;
      logic          dv;
      logic          pe;
      logic          se;
      logic [DW-1:0] d;
   } evt_t;

   evt_t          got_q[$];
   evt_t          exp_q[$];
   evt_t          mon_e;
   logic [DW-1:0] last_good;

   uart_rx_core #(.DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_in      (rx_in),
      .prescale   (prescale),
      .par_en     (par_en),
      .par_type   (par_type),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count rising edges; edge n is the n-th posedge since time 0.
   always @(posedge clk) cyc <= cyc + 1;

   // Log every cycle showing a pulse, stamped with the edge that samples it.
   always @(negedge clk) begin
      if (reset === 1'b1 && (data_valid === 1'b1 || par_err === 1'b1 || stp_err === 1'b1)) begin
         mon_e.t  = cyc + 1;
         mon_e.dv = data_valid;
         mon_e.pe = par_err;
         mon_e.se = stp_err;
         mon_e.d  = p_data;
         got_q.push_back(mon_e);
      end
   end

   // Drive one frame; the model then states what the receiver must report and when.
   task automatic send_frame(input logic [DW-1:0] d, input int p, input logic pen,
                             input logic ptype, input logic pbit_ok, input logic stop_bit,
                             input int glitch_bit, input int abort_at);
      logic bits[$];
      logic good_par;
      int   t0;
      int   k;
      evt_t e;
      good_par = ptype ? (^d) : ~(^d);
      bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) bits.push_back(d[i]);
      if (pen) bits.push_back(pbit_ok ? good_par : ~good_par);
      bits.push_back(stop_bit);
      prescale = 6'(p);
      par_en   = pen;
      par_type = ptype;
      t0 = cyc + 1;
      k  = 0;
      for (int i = 0; i < bits.size(); i++) begin
         for (int j = 0; j < p; j++) begin
            if (k == abort_at) begin
               reset = 1'b0;
               rx_in = 1'b1;
               last_good = '0;
               return;
            end
            rx_in = bits[i] ^ ((i == glitch_bit) && (j == p / 2));
            @(posedge clk);
            #1;
            k++;
         end
      end
      rx_in = 1'b1;
      e.t = t0 + bits.size() * p;
      if (!(pen && !pbit_ok) && stop_bit) begin
         last_good = d;
         e.dv = 1'b1;
         e.pe = 1'b0;
         e.se = 1'b0;
      end else begin
         e.dv = 1'b0;
         e.pe = pen && !pbit_ok;
         e.se = !stop_bit;
      end
      e.d = last_good;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      rx_in = 1'b1;
      prescale = 6'd8;
      par_en = 1'b0;
      par_type = 1'b0;
      last_good = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (p_data !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_p_data got=%h exp=00", p_data);
      end
      checks++;
      if ({data_valid, par_err, stp_err} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_pulses got=%b exp=000", {data_valid, par_err, stp_err});
      end
      reset = 1'b1;
      idle(5);
   endtask

   task automatic test_parity();
      send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
      idle(10);
      send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1);
      idle(20);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++;
         $display("[TB] FAIL parity_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL parity_evt%0d got t=%0d dv=%b pe=%b se=%b d=%h exp t=%0d dv=%b pe=%b se=%b d=%h",
                     i, got_q[i].t, got_q[i].dv, got_q[i].pe, got_q[i].se, got_q[i].d,
                     exp_q[i].t, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].d);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_stop();
      send_frame(8'h3C, 32, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
      idle(10);
      send_frame(8'h3C, 32, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
      idle(20);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++;
         $display("[TB] FAIL stop_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL stop_evt%0d got t=%0d dv=%b pe=%b se=%b d=%h exp t=%0d dv=%b pe=%b se=%b d=%h",
                     i, got_q[i].t, got_q[i].dv, got_q[i].pe, got_q[i].se, got_q[i].d,
                     exp_q[i].t, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].d);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   // A 3-tick low pulse is rejected; a start sampled right at T0+16 must then be accepted.
   task automatic test_glitch();
      prescale = 6'd16;
      par_en = 1'b1;
      par_type = 1'b1;
      rx_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rx_in = 1'b1;
      repeat (13) @(posedge clk);
      #1;
      send_frame(8'h5A, 16, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);
      idle(20);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++;
         $display("[TB] FAIL glitch_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL glitch_evt%0d got t=%0d dv=%b pe=%b se=%b d=%h exp t=%0d dv=%b pe=%b se=%b d=%h",
                     i, got_q[i].t, got_q[i].dv, got_q[i].pe, got_q[i].se, got_q[i].d,
                     exp_q[i].t, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].d);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      send_frame(8'h01, 16, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);
      send_frame(8'hFF, 16, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);
      idle(20);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++;
         $display("[TB] FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL b2b_evt%0d got t=%0d dv=%b pe=%b se=%b d=%h exp t=%0d dv=%b pe=%b se=%b d=%h",
                     i, got_q[i].t, got_q[i].dv, got_q[i].pe, got_q[i].se, got_q[i].d,
                     exp_q[i].t, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].d);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   // Abort in the middle of data bit 4, hold reset, then receive a clean frame.
   task automatic test_reset_midframe();
      send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, 1'b1, -1, 5 * 16 + 8);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if ({p_data, data_valid, par_err, stp_err} !== 11'd0) begin
         errors++;
         $display("[TB] FAIL midreset_outputs got=%h exp=000", {p_data, data_valid, par_err, stp_err});
      end
      reset = 1'b1;
      idle(400);
      send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
      idle(20);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++;
         $display("[TB] FAIL midreset_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL midreset_evt%0d got t=%0d dv=%b pe=%b se=%b d=%h exp t=%0d dv=%b pe=%b se=%b d=%h",
                     i, got_q[i].t, got_q[i].dv, got_q[i].pe, got_q[i].se, got_q[i].d,
                     exp_q[i].t, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].d);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   // Random words, rates, parity modes, corrupted parity/stop, single-sample noise and gaps.
   task automatic test_random();
      int p;
      int nbits;
      int gl;
      logic pen;
      for (int n = 0; n < 14; n++) begin
         case ($urandom_range(0, 2))
            0:       p = 8;
            1:       p = 16;
            default: p = 32;
         endcase
         pen   = 1'($urandom_range(0, 1));
         nbits = 2 + DW + int'(pen);
         gl    = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nbits - 1) : -1;
         send_frame(8'($urandom), p, pen, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), gl, -1);
         if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 20));
      end
      idle(40);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++;
         $display("[TB] FAIL random_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL random_evt%0d got t=%0d dv=%b pe=%b se=%b d=%h exp t=%0d dv=%b pe=%b se=%b d=%h",
                     i, got_q[i].t, got_q[i].dv, got_q[i].pe, got_q[i].se, got_q[i].d,
                     exp_q[i].t, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].d);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_parity();
      test_stop();
      test_glitch();
      test_back_to_back();
      test_reset_midframe();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receive engine: oversamples the serial line, deserializes one frame (start, DATA_WIDTH data bits LSB first, optional parity, one stop), and checks parity and stop.
- Parity rule mirrors the UART TX parity generator: expected bit = XOR(data) when par_type=1, ~XOR(data) when par_type=0.
- Sits between the RX pin synchronizer and the RX data synchronizer / system controller.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- clk  input  1  receive clock (oversampling clock).
- reset  input  1  asynchronous, active-low reset.
- rx_in  input  1  serial line, idle high, already synchronized.
- prescale  input  6  oversampling ratio; supported values 8, 16, 32.
- par_en  input  1  1 = parity bit present in frame.
- par_type  input  1  parity select (rule above).
- p_data  output  DATA_WIDTH  last good received word.
- data_valid  output  1  one-cycle pulse, p_data updated.
- par_err  output  1  one-cycle pulse, parity mismatch.
- stp_err  output  1  one-cycle pulse, stop bit sampled 0.

Behaviour:
- Reset (async, active-low, effective mid-frame): FSM to IDLE, all counters 0, p_data=0, data_valid=par_err=stp_err=0. No pulses are emitted for an aborted frame.
- prescale, par_en and par_type are captured at start detection and held for the whole frame. Unsupported prescale values are outside the contract.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: rx_in=0 sampled on a clk edge = start detection (cycle T0). Go to START with edge_cnt=1 (T0 counts as edge 0).
- edge_cnt counts 0..prescale-1 within each bit. At prescale-1 it wraps to 0 and the bit ends.
- Bit value = majority of rx_in sampled at edge_cnt = prescale/2-1, prescale/2, prescale/2+1. Majority is registered and valid from edge prescale/2+2.
- START: at bit end, majority=1 → glitch, return to IDLE with no outputs. Majority=0 → DATA, bit_cnt=0.
- DATA: at each bit end, majority is shifted into the internal shift register at position bit_cnt (LSB first). After bit DATA_WIDTH-1 → PARITY if par_en, else STOP.
- PARITY: at bit end, compare majority with the expected bit over the shifted data; mismatch sets the internal par_fail flag. Then → STOP.
- STOP: at bit end, majority=0 sets the internal stp_fail flag. Then → IDLE.
- Outputs are registered and asserted in the cycle after the final stop-bit edge, i.e. exactly (2+DATA_WIDTH+par_en)*prescale cycles after T0:
  - no failures: data_valid=1 and p_data loaded;
  - par_fail: par_err=1;
  - stp_fail: stp_err=1;
  - both failures: both error pulses in the same cycle.
- On any error, data_valid stays 0 and p_data holds its previous value. All pulses last exactly one cycle.
- Back-to-back frames: the FSM is in IDLE in the output cycle, and rx_in=0 in that same cycle is a valid start detection. No idle gap is required beyond the stop bit.
- rx_in activity during IDLE other than a falling level is ignored. A rx_in=0 held after a glitch rejection is detected again as a new start.
- Internal fail flags and the shift register are cleared at every start detection.

Test Plan:
- 0xA5, prescale=8, par_en=1, par_type=0, parity bit 1, stop 1 → data_valid pulse at T0+88, p_data=0xA5, no errors.
- Same frame with parity bit 0 → par_err pulse at T0+88, data_valid=0, p_data keeps its prior value (0x00 after reset).
- 0x3C, prescale=32, par_en=0, stop bit driven 0 → stp_err pulse at T0+320, data_valid=0; then a good 0x3C frame → data_valid at T0'+320, p_data=0x3C.
- Glitch: prescale=16, rx_in low for 3 cycles then high → FSM back in IDLE at T0+16, no pulses. A following good 0x5A frame (par_en=1, par_type=1, parity bit 0) is received correctly.
- Back-to-back 0x01 then 0xFF at prescale=16, par_en=1, par_type=1, with the second start bit beginning right after the first stop bit → two data_valid pulses 176 cycles apart, p_data=0x01 then 0xFF.
- Reset asserted at the DATA bit 4 midpoint, released, then a good 0x81 frame → no pulse from the aborted frame, outputs 0 during reset, then data_valid with p_data=0x81.
